inertial_delay_line: RTL and testbench
======================================

# inertial_delay_line

Clocked, synthesizable, multi-channel delay line that models gate propagation delay in cycles rather than `#` time units. Each channel propagates a 1-bit level change to its output after DELAY clock cycles. In inertial mode it rejects pulses narrower than DELAY; in transport mode it passes every pulse. It sits between stimulus/control logic and downstream consumers that need deterministic, filtered, cycle-accurate delays, such as debounce, glitch suppression and delay modelling in synthesizable benches.

## Interface
Parameters:
- CH, 3: number of independent channels.
- DELAY, 20: delay in clock cycles; legal range ≥ 1.
- MODE, IDL_INERTIAL: IDL_INERTIAL rejects short pulses; IDL_TRANSPORT is a pure delay.
- RST_VAL, '0: CH-bit reset value of dout.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global clock enable; when low, all state and outputs freeze.
- din  input  CH  channel inputs, synchronous to clk.
- dout  output  CH  delayed/filtered outputs, registered.
- busy  output  CH  channel has a pending (not yet committed) change.
- reject  output  CH  1-cycle strobe when a pending change is cancelled (inertial mode only).

## Operation
- Per-channel counter width is $clog2(DELAY+1). Counter value is in the range 0..DELAY-1.
- Inertial mode FSM per channel, states IDLE and PEND:
  - IDLE: if din != dout, go to PEND with target <= din and cnt <= 1. If DELAY == 1, commit immediately: dout <= din and stay in IDLE.
  - PEND, din == target: if cnt == DELAY-1, then dout <= target, cnt <= 0, next state IDLE. Otherwise cnt <= cnt+1.
  - PEND, din != target (input returned to dout): reject <= 1 for one cycle, cnt <= 0, next state IDLE.
  - busy = (state == PEND).
- Transport mode per channel:
  - DELAY-stage shift register; stage0 <= din; dout = stage[DELAY-1].
  - busy = OR over stages of (stage != dout).
  - reject is held at 0.
- Simultaneous events: channels are fully independent. Any mix of commits and rejects in the same cycle is legal.
- en == 0: no counter advance, no shift, no strobe. Pending changes resume when en returns high. Input changes while en is low are not sampled.

## Timing
- Reset (async assert, clean release on clk): dout = RST_VAL, busy = 0, reject = 0, all counters = 0, FSM in IDLE, shift stages = RST_VAL.
- Latency, both modes: dout takes a new value on the DELAY-th consecutive enabled sampling edge that sees that value on din. Changes are visible right after that edge.
- Inertial pulse widths:
  - A pulse held for ≥ DELAY sampling edges passes.
  - A pulse held for < DELAY sampling edges is dropped. reject asserts on the edge that sees din revert.
- reject is registered and high for exactly one cycle per cancelled change.
- Reset asserted mid-PEND: the pending change is discarded with no reject strobe, and dout is forced to RST_VAL asynchronously.

## Configuration
- INERTIAL_DELAY_REJECT_CNT_EN defined:
  - Adds output port reject_cnt, CH*16 bits.
  - Per channel, a 16-bit saturating count of reject strobes. It holds at 16'hFFFF and resets to 0.
  - In transport mode the count stays 0.
- Macro undefined: the port and counters do not exist. Behaviour is otherwise identical.

## Structure
- Package inertial_delay_pkg:
  - typedef enum idl_mode_e {IDL_INERTIAL, IDL_TRANSPORT}.
  - typedef enum idl_state_e {IDL_IDLE, IDL_PEND}.
  - localparam REJ_CNT_W = 16.
- Sub-module inertial_delay_ch: implements one channel (FSM or shift register selected by MODE, plus the optional reject counter). The top instantiates it CH times in a generate loop.

## Test plan
- Reset check: CH=3, DELAY=20, RST_VAL=3'b010. Assert rst mid-cycle -> dout=3'b010, busy=0, reject=0 immediately, without a clock edge.
- Pass in inertial mode: ch0 rises and holds 35 cycles -> dout[0] rises on the 20th sampling edge, falls 20 edges after din falls; reject never asserts.
- Reject in inertial mode: ch0 high for 10 cycles -> dout[0] stays 0; reject[0] pulses once on the revert edge; reject_cnt[0]=1 when the macro is enabled.
- Boundary widths: pulse of exactly 20 cycles -> passes with width 20. Pulse of 19 cycles -> rejected. DELAY=1 -> dout equals din registered once.
- Transport mode, DELAY=5: 2-cycle pulse -> appears on dout 5 edges later with width 2; reject stays 0.
- en and reset interaction: en low for 7 cycles during PEND -> commit is delayed by exactly 7 cycles. rst asserted mid-PEND -> no commit and no reject.

Source files
------------

// File: rtl/inertial_delay_pkg.sv
// Shared types for the inertial delay line: channel mode, channel FSM
// state and reject counter width.
package inertial_delay_pkg;

  typedef enum logic {
    IDL_INERTIAL,
    IDL_TRANSPORT
  } idl_mode_e;

  typedef enum logic {
    IDL_IDLE,
    IDL_PEND
  } idl_state_e;

  localparam int REJ_CNT_W = 16;

endpackage

// File: rtl/inertial_delay_ch.sv
// One delay channel: inertial pulse filter or transport shift register.
// INERTIAL_DELAY_REJECT_CNT_EN adds a saturating reject counter.
module inertial_delay_ch
  import inertial_delay_pkg::*;
#(
  parameter int        DELAY   = 20,
  parameter idl_mode_e MODE    = IDL_INERTIAL,
  parameter logic      RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic dout,
  output logic busy,
  output logic reject
`ifdef INERTIAL_DELAY_REJECT_CNT_EN
  ,
  output logic [REJ_CNT_W-1:0] reject_cnt
`endif
);

  localparam int CW = $clog2(DELAY + 1);

  if (MODE == IDL_INERTIAL) begin : g_inr
    idl_state_e    state;
    idl_state_e    state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          tgt;
    logic          tgt_nx;
    logic          dout_nx;
    logic          rej_nx;

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      tgt_nx   = tgt;
      dout_nx  = dout;
      rej_nx   = 1'b0;
      if (en) begin
        unique case (state)
          IDL_IDLE: begin
            if (din != dout) begin
              if (DELAY == 1) begin
                dout_nx = din;
              end else begin
                state_nx = IDL_PEND;
                tgt_nx   = din;
                cnt_nx   = CW'(1);
              end
            end
          end
          IDL_PEND: begin
            if (din == tgt) begin
              if (cnt == CW'(DELAY - 1)) begin
                dout_nx  = tgt;
                cnt_nx   = '0;
                state_nx = IDL_IDLE;
              end else begin
                cnt_nx = cnt + 1'b1;
              end
            end else begin
              // input fell back to dout before the delay elapsed
              rej_nx   = 1'b1;
              cnt_nx   = '0;
              state_nx = IDL_IDLE;
            end
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state  <= IDL_IDLE;
        cnt    <= '0;
        tgt    <= RST_VAL;
        dout   <= RST_VAL;
        reject <= 1'b0;
      end else begin
        state  <= state_nx;
        cnt    <= cnt_nx;
        tgt    <= tgt_nx;
        dout   <= dout_nx;
        reject <= rej_nx;
      end
    end

    assign busy = (state == IDL_PEND);

`ifdef INERTIAL_DELAY_REJECT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        reject_cnt <= '0;
      end else if (rej_nx && (reject_cnt != '1)) begin
        reject_cnt <= reject_cnt + 1'b1;
      end
    end
`endif
  end else begin : g_trn
    logic [DELAY-1:0] stg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stg <= {DELAY{RST_VAL}};
      end else if (en) begin
        stg <= (stg << 1) | DELAY'(din);
      end
    end

    assign dout   = stg[DELAY-1];
    assign busy   = |(stg ^ {DELAY{stg[DELAY-1]}});
    assign reject = 1'b0;

`ifdef INERTIAL_DELAY_REJECT_CNT_EN
    assign reject_cnt = '0;
`endif
  end

endmodule

// File: rtl/inertial_delay_line.sv
// Multi-channel clocked delay line with inertial or transport behaviour.
// Define INERTIAL_DELAY_REJECT_CNT_EN for per-channel reject counters.
module inertial_delay_line
  import inertial_delay_pkg::*;
#(
  parameter int          CH      = 3,
  parameter int          DELAY   = 20,
  parameter idl_mode_e   MODE    = IDL_INERTIAL,
  parameter logic [CH-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CH-1:0] din,
  output logic [CH-1:0] dout,
  output logic [CH-1:0] busy,
  output logic [CH-1:0] reject
`ifdef INERTIAL_DELAY_REJECT_CNT_EN
  ,
  output logic [CH*REJ_CNT_W-1:0] reject_cnt
`endif
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    inertial_delay_ch #(
      .DELAY   (DELAY),
      .MODE    (MODE),
      .RST_VAL (RST_VAL[i])
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .din    (din[i]),
      .dout   (dout[i]),
      .busy   (busy[i]),
      .reject (reject[i])
`ifdef INERTIAL_DELAY_REJECT_CNT_EN
      ,
      .reject_cnt (reject_cnt[i*REJ_CNT_W +: REJ_CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_inertial_delay_line.sv
// Bench for inertial_delay_line: three configurations driven in parallel
// and compared every cycle with a sample-history reference model.
module tb_inertial_delay_line;
  import inertial_delay_pkg::*;

  localparam int ND   = 3;
  localparam int HMAX = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] din;
  logic [2:0] dout [ND];
  logic [2:0] busy [ND];
  logic [2:0] rej  [ND];
`ifdef INERTIAL_DELAY_REJECT_CNT_EN
  logic [47:0] rcnt [ND];
`endif

  int n_chk = 0;
  int n_err = 0;
  int rej_seen = 0;

  always #5 clk = ~clk;

  inertial_delay_line #(
    .CH(3), .DELAY(20), .MODE(IDL_INERTIAL), .RST_VAL(3'b010)
  ) u_a (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .dout(dout[0]), .busy(busy[0]), .reject(rej[0])
`ifdef INERTIAL_DELAY_REJECT_CNT_EN
    , .reject_cnt(rcnt[0])
`endif
  );

  inertial_delay_line #(
    .CH(3), .DELAY(1), .MODE(IDL_INERTIAL), .RST_VAL(3'b000)
  ) u_b (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .dout(dout[1]), .busy(busy[1]), .reject(rej[1])
`ifdef INERTIAL_DELAY_REJECT_CNT_EN
    , .reject_cnt(rcnt[1])
`endif
  );

  inertial_delay_line #(
    .CH(3), .DELAY(5), .MODE(IDL_TRANSPORT), .RST_VAL(3'b000)
  ) u_c (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .dout(dout[2]), .busy(busy[2]), .reject(rej[2])
`ifdef INERTIAL_DELAY_REJECT_CNT_EN
    , .reject_cnt(rcnt[2])
`endif
  );

  function automatic int dly_of(input int d);
    return (d == 0) ? 20 : ((d == 1) ? 1 : 5);
  endfunction

  function automatic bit tr_of(input int d);
    return d == 2;
  endfunction

  function automatic logic [2:0] rv_of(input int d);
    return (d == 0) ? 3'b010 : 3'b000;
  endfunction

  // reference state: last HMAX enabled samples per channel, newest at [0]
  bit hist   [ND][3][HMAX];
  bit m_dout [ND][3];
  bit m_busy [ND][3];
  bit m_rej  [ND][3];
  int m_cnt  [ND][3];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset;
    logic [2:0] rv;
    for (int d = 0; d < ND; d++) begin
      rv = rv_of(d);
      for (int c = 0; c < 3; c++) begin
        for (int k = 0; k < HMAX; k++) hist[d][c][k] = rv[c];
        m_dout[d][c] = rv[c];
        m_busy[d][c] = 1'b0;
        m_rej[d][c]  = 1'b0;
        m_cnt[d][c]  = 0;
      end
    end
  endtask

  // Inertial: dout takes value v once the last DELAY samples are all v.
  // A reject happens when a sample equals dout right after one that did not.
  // Transport: dout is the sample taken DELAY enabled edges ago.
  task automatic model_step(input logic [2:0] s);
    int n;
    bit prev;
    bit all;
    for (int d = 0; d < ND; d++) begin
      n = dly_of(d);
      for (int c = 0; c < 3; c++) begin
        prev = hist[d][c][0];
        for (int k = HMAX - 1; k > 0; k--) hist[d][c][k] = hist[d][c][k-1];
        hist[d][c][0] = s[c];
        if (tr_of(d)) begin
          m_dout[d][c] = hist[d][c][n-1];
          m_rej[d][c]  = 1'b0;
          m_busy[d][c] = 1'b0;
          for (int k = 0; k < n; k++)
            if (hist[d][c][k] != m_dout[d][c]) m_busy[d][c] = 1'b1;
        end else begin
          m_rej[d][c] = (s[c] == m_dout[d][c]) && (prev != m_dout[d][c]);
          all = 1'b1;
          for (int k = 0; k < n; k++)
            if (hist[d][c][k] != s[c]) all = 1'b0;
          if (all) m_dout[d][c] = s[c];
          m_busy[d][c] = (s[c] != m_dout[d][c]);
          if (m_rej[d][c] && m_cnt[d][c] < 65535) m_cnt[d][c]++;
        end
      end
    end
  endtask

  task automatic model_hold;
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < 3; c++) m_rej[d][c] = 1'b0;
  endtask

  task automatic compare;
    logic [2:0] ed, eb, er;
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < 3; c++) begin
        ed[c] = m_dout[d][c];
        eb[c] = m_busy[d][c];
        er[c] = m_rej[d][c];
`ifdef INERTIAL_DELAY_REJECT_CNT_EN
        chk($sformatf("rcnt%0d_%0d", d, c), rcnt[d][c*16 +: 16],
            64'(m_cnt[d][c]));
`endif
      end
      chk($sformatf("dout%0d", d), dout[d], ed);
      chk($sformatf("busy%0d", d), busy[d], eb);
      chk($sformatf("reject%0d", d), rej[d], er);
    end
  endtask

  task automatic cyc(input logic [2:0] d, input logic e);
    din = d;
    en  = e;
    @(posedge clk);
    if (e) model_step(d);
    else model_hold();
    #1;
    if (rej[0][0]) rej_seen++;
    compare();
  endtask

  task automatic cycn(input int n, input logic [2:0] d, input logic e);
    for (int i = 0; i < n; i++) cyc(d, e);
  endtask

  // asserted between edges; outputs must change without a clock
  task automatic do_reset;
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_dout_a", dout[0], 3'b010);
    chk("rst_busy_a", busy[0], 3'b000);
    chk("rst_rej_a", rej[0], 3'b000);
    compare();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] rd;
    rst = 1'b0;
    en  = 1'b0;
    din = 3'b000;
    #1;
    do_reset();
    cycn(5, 3'b000, 1'b1);

    // long pulse: commit on the 20th edge, falls 20 edges later
    cycn(19, 3'b001, 1'b1);
    chk("pre_commit", dout[0][0], 1'b0);
    cyc(3'b001, 1'b1);
    chk("commit20", dout[0][0], 1'b1);
    cycn(15, 3'b001, 1'b1);
    cycn(19, 3'b000, 1'b1);
    chk("pre_fall", dout[0][0], 1'b1);
    cyc(3'b000, 1'b1);
    chk("fall20", dout[0][0], 1'b0);
    cycn(5, 3'b000, 1'b1);

    // short pulse rejected once
    rej_seen = 0;
    cycn(10, 3'b001, 1'b1);
    cycn(30, 3'b000, 1'b1);
    chk("rej_once", 64'(rej_seen), 64'd1);
`ifdef INERTIAL_DELAY_REJECT_CNT_EN
    chk("rcnt_once", rcnt[0][15:0], 16'd1);
`endif

    // boundary widths
    cycn(20, 3'b001, 1'b1);
    chk("w20_pass", dout[0][0], 1'b1);
    cycn(30, 3'b000, 1'b1);
    cycn(19, 3'b001, 1'b1);
    cycn(30, 3'b000, 1'b1);
    chk("w19_drop", dout[0][0], 1'b0);

    // transport 2-cycle pulse
    cycn(2, 3'b001, 1'b1);
    cycn(15, 3'b000, 1'b1);

    // enable gap during PEND; din toggles while frozen are ignored
    cycn(5, 3'b001, 1'b1);
    cycn(3, 3'b001, 1'b0);
    cycn(2, 3'b000, 1'b0);
    cycn(2, 3'b001, 1'b0);
    cycn(14, 3'b001, 1'b1);
    chk("en_pre", dout[0][0], 1'b0);
    cyc(3'b001, 1'b1);
    chk("en_commit", dout[0][0], 1'b1);
    cycn(30, 3'b000, 1'b1);

    // reset mid-PEND
    cycn(10, 3'b001, 1'b1);
    din = 3'b000;
    do_reset();
    cycn(30, 3'b000, 1'b1);

    // randomized phase
    rd = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 3; c++)
        if ($urandom_range(0, 11) == 0) rd[c] = ~rd[c];
      cyc(rd, $urandom_range(0, 9) != 0);
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
